// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder:
// frame FSM states, prefix byte codes, key-bus field positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int KEY_W        = 11;
  localparam int KEY_TOGGLE   = 10;
  localparam int KEY_PRESSED  = 9;
  localparam int KEY_EXT      = 8;
  localparam int KEY_CODE_MSB = 7;

  // Odd parity holds when the data bits and the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line;
// emits a one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             fall_q, fall_d;

  // The level flips only on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        cnt_d   = '0;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, filter state and edge pulse registers; idle line level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= line_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scancode-to-key-event decoder
// with E0/F0 prefix tracking, parity/stop checking and inter-edge timeout.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter real CLK_FREQ   = 96.0,
  parameter int  TIMEOUT_US = 2000,
  parameter int  FILTER_LEN = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [KEY_W-1:0]  ps2_key,
  output logic              key_strobe,
  output logic              frame_err
);

  localparam int TIMEOUT_CYC = $rtoi(CLK_FREQ * TIMEOUT_US);
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic             clk_fall_s;
  logic             dat_s1_q, dat_sync_q;
  logic             timeout_s;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             strobe_q, strobe_d, err_q, err_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .line_i (ps2_clk),
    .fall_o (clk_fall_s)
  );

  // Plain two-flop synchroniser for the data line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dat_s1_q   <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      dat_s1_q   <= ps2_dat;
      dat_sync_q <= dat_s1_q;
    end
  end

  assign timeout_s = (state_q != ST_IDLE) && !clk_fall_s && (to_q == TO_LAST);

  // Frame state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next frame state: one step per filtered falling edge, timeout aborts to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clk_fall_s && !dat_sync_q) state_d = ST_DATA;
        else                           state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (timeout_s)                             state_d = ST_IDLE;
        else if (clk_fall_s && bit_cnt_q == 3'd7)  state_d = ST_PARITY;
        else                                       state_d = ST_DATA;
      end
      ST_PARITY: begin
        if (timeout_s)       state_d = ST_IDLE;
        else if (clk_fall_s) state_d = ST_STOP;
        else                 state_d = ST_PARITY;
      end
      ST_STOP: begin
        if (timeout_s || clk_fall_s) state_d = ST_IDLE;
        else                         state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and event outputs: shifting, parity, prefix flags, key bus, pulses.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    to_d      = '0;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;

    if (state_q == ST_IDLE || clk_fall_s) begin
      to_d = '0;
    end else if (timeout_s) begin
      to_d  = '0;
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (clk_fall_s && !dat_sync_q) bit_cnt_d = 3'd0;
        else                           bit_cnt_d = bit_cnt_q;
      end
      ST_DATA: begin
        if (clk_fall_s) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          shift_d = shift_q;
        end
      end
      ST_PARITY: begin
        if (clk_fall_s) par_ok_d = odd_parity_ok(shift_q, dat_sync_q);
        else            par_ok_d = par_ok_q;
      end
      ST_STOP: begin
        if (clk_fall_s && dat_sync_q && par_ok_q) begin
          case (shift_q)
            PS2_EXT:   ext_d = 1'b1;
            PS2_BRK:   brk_d = 1'b1;
            PS2_PAUSE: begin
              ext_d = ext_q;
              brk_d = brk_q;
            end
            default: begin
              key_d[KEY_TOGGLE]       = ~key_q[KEY_TOGGLE];
              key_d[KEY_PRESSED]      = ~brk_q;
              key_d[KEY_EXT]          = ext_q;
              key_d[KEY_CODE_MSB:0]   = shift_q;
              strobe_d                = 1'b1;
              ext_d                   = 1'b0;
              brk_d                   = 1'b0;
            end
          endcase
        end else if (clk_fall_s) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          key_d = key_q;
        end
      end
      default: begin
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Datapath registers; outputs come straight from flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_ok_q  <= 1'b0;
      to_q      <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_q     <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      to_q      <= to_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      key_q     <= key_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and
// checks the key bus, event/error pulse counts and frame state.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  logic        clk_sys;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int n_both   = 0;

  ps2_key_decoder #(
    .CLK_FREQ   (1.0),
    .TIMEOUT_US (300),
    .FILTER_LEN (8)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (key_strobe) n_strobe <= n_strobe + 1;
    if (frame_err)  n_err    <= n_err + 1;
    if (key_strobe && frame_err) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (20) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit((~^data) ^ bad_par);
    send_bit(stop);
    ps2_dat = 1'b1;
    repeat (30) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic good(input logic [7:0] data);
    send_frame(data, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_strobe", 32'(key_strobe), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);

    // make code after reset
    good(8'h1C);
    check("make_1c", 32'(ps2_key), 32'h61C);
    check("make_1c_toggle", 32'(ps2_key[10]), 32'h1);
    check("make_1c_strobes", 32'(n_strobe), 32'd1);

    // break code
    good(8'hF0); good(8'h1C);
    check("brk_1c", 32'(ps2_key[9:0]), 32'h01C);
    check("brk_1c_toggle", 32'(ps2_key[10]), 32'h0);
    check("brk_1c_strobes", 32'(n_strobe), 32'd2);

    // extended make then extended break
    good(8'hE0); good(8'h75);
    check("ext_make_75", 32'(ps2_key[9:0]), 32'h375);
    good(8'hE0); good(8'hF0); good(8'h75);
    check("ext_brk_75", 32'(ps2_key[9:0]), 32'h175);
    check("ext_strobes", 32'(n_strobe), 32'd4);

    // bad parity then a good break
    send_frame(8'h29, 1'b1, 1'b1);
    check("par_err_count", 32'(n_err), 32'd1);
    check("par_err_key", 32'(ps2_key), 32'h175);
    check("par_err_strobes", 32'(n_strobe), 32'd4);
    good(8'hF0); good(8'h29);
    check("brk_29", 32'(ps2_key[9:0]), 32'h029);
    check("brk_29_full", 32'(ps2_key), 32'h429);

    // prefix then partial frame timing out; prefix must be cleared
    good(8'hE0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (400) @(posedge clk_sys);
    @(negedge clk_sys);
    check("timeout_err", 32'(n_err), 32'd2);
    check("timeout_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("timeout_key", 32'(ps2_key), 32'h429);
    good(8'h5A);
    check("after_to_5a_code", 32'(ps2_key[7:0]), 32'h5A);
    check("after_to_5a_full", 32'(ps2_key), 32'h25A);

    // pause byte dropped, then typematic repeats
    good(8'hE1);
    check("pause_no_strobe", 32'(n_strobe), 32'd6);
    good(8'h1C);
    check("typematic_1", 32'(ps2_key), 32'h61C);
    good(8'h1C);
    check("typematic_2", 32'(ps2_key), 32'h21C);
    check("typematic_strobes", 32'(n_strobe), 32'd8);

    // short glitches on the clock line with data low
    ps2_dat = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk_sys);
    end
    ps2_dat = 1'b1;
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    check("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
    good(8'h34);
    check("glitch_then_34", 32'(ps2_key), 32'h634);
    check("glitch_err", 32'(n_err), 32'd2);

    // reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("midreset_key", 32'(ps2_key), 32'h000);
    reset_n = 1'b1;
    repeat (400) @(posedge clk_sys);
    @(negedge clk_sys);
    check("midreset_err", 32'(n_err), 32'd2);
    check("midreset_strobes", 32'(n_strobe), 32'd9);
    good(8'h16);
    check("after_reset_16", 32'(ps2_key[9:0]), 32'h216);
    check("after_reset_16_toggle", 32'(ps2_key[10]), 32'h1);

    // bad stop bit clears a pending prefix
    good(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0);
    check("stop_err", 32'(n_err), 32'd3);
    check("stop_err_key", 32'(ps2_key), 32'h616);
    good(8'h33);
    check("after_stop_33", 32'(ps2_key), 32'h233);
    check("total_strobes", 32'(n_strobe), 32'd11);
    check("never_both", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 96.0, system clock frequency in MHz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between falling PS/2 clock edges inside one frame, in microseconds.
REQ-003 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples that validates a PS/2 clock level.
REQ-004 SHALL have port clk_sys  in  1  system clock; one clock domain only.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_dat  in  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-008 SHALL have port ps2_key  out  11  key event bus: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-009 SHALL have port key_strobe  out  1  one-cycle pulse, asserted in the same cycle ps2_key changes.
REQ-010 SHALL have port frame_err  out  1  one-cycle pulse on each discarded frame (parity, stop-bit or timeout failure).

Function
REQ-011 SHALL pass ps2_clk and ps2_dat through two-flop synchronisers before any use.
REQ-012 SHALL hold a filtered clock level that changes only after FILTER_LEN consecutive equal synchronised samples.
REQ-013 SHALL sample synchronised ps2_dat exactly once per falling edge of the filtered clock.
REQ-014 SHALL run a frame FSM with states IDLE, DATA, PARITY, STOP.
REQ-015 In IDLE, a sampled 0 SHALL enter DATA with bit count 0; a sampled 1 SHALL keep IDLE and raise no error.
REQ-016 In DATA, bits SHALL shift in LSB first; after the 8th bit the FSM SHALL enter PARITY.
REQ-017 In PARITY, the FSM SHALL record odd-parity validity (XOR of the 8 data bits and the parity bit equals 1) and enter STOP.
REQ-018 In STOP, the FSM SHALL return to IDLE; the byte is accepted only if the stop bit is 1 and parity is valid, otherwise frame_err SHALL pulse.
REQ-019 A 3-bit bit counter SHALL be used; the count wrap from 7 SHALL coincide with the DATA-to-PARITY transition.
REQ-020 A timeout counter sized from CLK_FREQ*TIMEOUT_US SHALL clear on every filtered falling edge and run in DATA, PARITY and STOP; on expiry the FSM SHALL go to IDLE, frame_err SHALL pulse, and the prefix flags SHALL clear.
REQ-021 Accepted byte 0xE0 SHALL set the ext flag and produce no event.
REQ-022 Accepted byte 0xF0 SHALL set the brk flag and produce no event.
REQ-023 Accepted byte 0xE1 SHALL be dropped with both flags unchanged.
REQ-024 Any other accepted byte SHALL, in the cycle after the stop bit is sampled:
- load ps2_key[7:0] with the byte;
- load [8] with ext and [9] with ~brk;
- invert [10];
- pulse key_strobe;
- clear ext and brk.
REQ-025 A rejected frame SHALL clear ext and brk and SHALL leave ps2_key unchanged.
REQ-026 key_strobe and frame_err SHALL never be asserted in the same cycle.
REQ-027 Repeated identical make codes (typematic) SHALL each produce an event and a toggle.

Reset
REQ-028 While reset_n is low, the following SHALL hold:
- ps2_key = 0, key_strobe = 0, frame_err = 0;
- FSM in IDLE, ext and brk flags = 0;
- bit, filter and timeout counters = 0;
- synchronisers and filtered clock = 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse; after release, decoding SHALL resume at the next start bit.

Structure
REQ-030 A shared package ps2_pkg SHALL hold:
- the FSM state enum;
- byte constants PS2_EXT = 0xE0, PS2_BRK = 0xF0, PS2_PAUSE = 0xE1;
- the ps2_key field index constants.
REQ-031 The clock synchroniser and glitch filter SHALL be a single sub-module, ps2_line_filter, instantiated once for ps2_clk; ps2_dat SHALL use a plain two-flop synchroniser.

Verification
REQ-032 The bench SHALL cover: frame 0x1C with good parity and stop -> ps2_key = 0x61C after reset, key_strobe pulses once, ps2_key[10] = 1.
REQ-033 The bench SHALL cover: frames F0, 1C -> ps2_key[9:0] = 0x01C, toggle inverted, exactly one key_strobe.
REQ-034 The bench SHALL cover: frames E0, 75 then E0, F0, 75 -> ps2_key[9:0] = 0x375, then 0x175, with two strobes.
REQ-035 The bench SHALL cover: frame 0x29 with bad parity -> frame_err pulses once, ps2_key unchanged; following F0, 29 -> ps2_key[9:0] = 0x029.
REQ-036 The bench SHALL cover: 4 data bits then silence longer than TIMEOUT_US -> frame_err pulses once, FSM in IDLE; next full 0x5A frame -> ps2_key[7:0] = 0x5A.
REQ-037 The bench SHALL cover: 2-cycle glitches on ps2_clk -> no bit sampled; reset_n pulsed low mid-frame -> no event and no frame_err, and the next 0x16 frame decodes as 0x216 with toggle from 0.
